// File: rtl/port_uart_pkg.sv
// Shared constants and helpers for the port_out_uart_hex block.
// FSM state encodings, the line-ending characters and the nibble-to-ASCII map.
package port_uart_pkg;

    // FSM state encodings (IDLE, LOAD, SEND, DONE)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] r;
        if (nib < 4'd10) begin
            r = 8'h30 + {4'h0, nib};
        end else begin
            r = 8'h37 + {4'h0, nib};
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-character UART transmitter: start bit, 8 data bits LSB first,
// optional even parity bit (macro PORT_UART_HEX_PARITY_EN), stop bit.
// ready is also high during the last cycle of the stop bit so a new
// character can start with no idle gap.
module uart_tx_byte #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       ready
);

`ifdef PORT_UART_HEX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

    logic                  active_q;
    logic [BW-1:0]         baud_q;
    logic [3:0]            bit_q;
    logic [FRAME_BITS-2:0] shift_q;
    logic                  tx_q;
    logic [FRAME_BITS-2:0] frame_s;
    logic                  last_tick_s;

    // Bits that follow the start bit, in transmission order (LSB first)
`ifdef PORT_UART_HEX_PARITY_EN
    assign frame_s = {1'b1, ^byte_in, byte_in};
`else
    assign frame_s = {1'b1, byte_in};
`endif

    assign last_tick_s = active_q && (baud_q == BAUD_LAST) && (bit_q == BIT_LAST);
    assign ready       = !active_q || last_tick_s;
    assign tx          = tx_q;

    // Baud timing, bit counting and shifting of the current frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '1;
            tx_q     <= 1'b1;
        end else if (start && ready) begin
            active_q <= 1'b1;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= frame_s;
            tx_q     <= 1'b0;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_q <= '0;
                if (bit_q == BIT_LAST) begin
                    active_q <= 1'b0;
                    tx_q     <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b1, shift_q[FRAME_BITS-2:1]};
                end
            end else begin
                baud_q <= baud_q + BW'(1);
            end
        end else begin
            tx_q <= 1'b1;
        end
    end

endmodule

// File: rtl/port_out_uart_hex.sv
// Watches the CPU output port and, on each change, sends its value as
// DATA_WIDTH/4 uppercase hex digits followed by CR LF over UART.
// DATA_WIDTH must be a multiple of 4. Optional even parity per character
// is enabled with the macro PORT_UART_HEX_PARITY_EN.
module port_out_uart_hex
    import port_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int NUM_DIGITS = DATA_WIDTH / 4;
    localparam int NUM_CHARS  = NUM_DIGITS + 2;
    localparam int IW         = $clog2(NUM_CHARS + 1);

    logic [1:0]            state_q, state_d;
    // Doubles as the message snapshot: it only changes when leaving IDLE
    logic [DATA_WIDTH-1:0] last_sent_q, last_sent_d;
    logic [IW-1:0]         char_idx_q, char_idx_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic                  start_s;
    logic                  ready_s;
    logic [3:0]            nib_s;
    logic [7:0]            char_s;

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .start   (start_s),
        .byte_in (char_s),
        .tx      (tx),
        .ready   (ready_s)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Select the nibble for the current character, most significant first
    always_comb begin
        nib_s = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (char_idx_q == IW'(i)) begin
                nib_s = last_sent_q[4*(NUM_DIGITS-1-i) +: 4];
            end else begin
                nib_s = nib_s;
            end
        end
    end

    // Map the character index to a hex digit, CR or LF
    always_comb begin
        if (char_idx_q < IW'(NUM_DIGITS)) begin
            char_s = nibble_to_ascii(nib_s);
        end else if (char_idx_q == IW'(NUM_DIGITS)) begin
            char_s = ASCII_CR;
        end else begin
            char_s = ASCII_LF;
        end
    end

    // Message FSM: change detection, character sequencing, busy/done flags
    always_comb begin
        state_d      = state_q;
        last_sent_d  = last_sent_q;
        char_idx_d   = char_idx_q;
        busy_d       = busy_q;
        frame_done_d = frame_done_q;
        start_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_in != last_sent_q) begin
                    last_sent_d = data_in;
                    char_idx_d  = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                start_s    = 1'b1;
                char_idx_d = char_idx_q + IW'(1);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (ready_s) begin
                    if (char_idx_q == IW'(NUM_CHARS)) begin
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        start_s    = 1'b1;
                        char_idx_d = char_idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                busy_d       = 1'b0;
                frame_done_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_sent_q  <= '0;
            char_idx_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_sent_q  <= last_sent_d;
            char_idx_q   <= char_idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_port_out_uart_hex.sv
// Directed bench for port_out_uart_hex with BAUD_DIV=4, DATA_WIDTH=32.
// A UART monitor decodes tx into bytes; each test compares the decoded
// text, frame_done count and timing against hand-computed values.
module tb_port_out_uart_hex;

    localparam int BAUD = 4;
    localparam int DW   = 32;
`ifdef PORT_UART_HEX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int MSG_CYC = 10 * FB * BAUD;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          tx;
    logic          busy;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    port_out_uart_hex #(
        .BAUD_DIV   (BAUD),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // UART monitor state
    logic [7:0] rx_q[$];
    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh  = 8'h00;
    int         frm_err = 0;
    int         fd_cnt  = 0;

    // Decode tx: detect start, sample each bit near its middle
    always @(negedge clk) begin
        if (reset) begin
            mon_act <= 1'b0;
            mon_cnt <= 0;
        end else if (!mon_act) begin
            if (tx == 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= BAUD + 2 && mon_cnt <= 8*BAUD + 2 && ((mon_cnt - 2) % BAUD) == 0)
                mon_sh <= {tx, mon_sh[7:1]};
            if (FB == 11 && mon_cnt == 9*BAUD + 2 && tx !== ^mon_sh)
                frm_err <= frm_err + 1;
            if (mon_cnt == (FB-1)*BAUD + 2) begin
                if (tx !== 1'b1) frm_err <= frm_err + 1;
                rx_q.push_back(mon_sh);
                mon_act <= 1'b0;
            end
        end
    end

    // Count frame_done pulses
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    function automatic string q2s();
        string s = "";
        foreach (rx_q[i]) begin
            if (rx_q[i] == 8'h0D) s = {s, "<CR>"};
            else if (rx_q[i] == 8'h0A) s = {s, "<LF>"};
            else s = {s, $sformatf("%c", rx_q[i])};
        end
        return s;
    endfunction

    task automatic test_reset();
        int tx_low = 0;
        int busy_hi = 0;
        int fd_hi = 0;
        reset = 1'b1;
        data_in = '0;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
        reset = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
            if (frame_done !== 1'b0) fd_hi++;
        end
        total++; if (tx_low != 0) begin bad++; $display("FAIL zero_tx_idle: got %0d low cycles expected 0", tx_low); end
        total++; if (busy_hi != 0) begin bad++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_hi); end
        total++; if (fd_hi != 0 || fd_cnt != 0) begin bad++; $display("FAIL zero_fd: got %0d pulses expected 0", fd_cnt); end
        total++; if (rx_q.size() != 0) begin bad++; $display("FAIL zero_rx: got %0d bytes expected 0", rx_q.size()); end
    endtask

    task automatic test_single();
        int cnt = 0;
        rx_q.delete();
        @(negedge clk);
        data_in = 32'h0000_002A;
        @(posedge clk); #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL lat_tx1: got %b expected 1", tx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL load_busy: got %b expected 1", busy); end
        @(posedge clk); #1;
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL lat_tx2: got %b expected 0", tx); end
        while (frame_done !== 1'b1 && cnt < 2*MSG_CYC) begin
            @(posedge clk); #1;
            cnt++;
        end
        total++; if (cnt != MSG_CYC) begin bad++; $display("FAIL msg_len: got %0d expected %0d", cnt, MSG_CYC); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL fd_pulse: got %b expected 0", frame_done); end
        @(negedge clk);
        total++; if (q2s() != "0000002A<CR><LF>") begin bad++; $display("FAIL single_msg: got %s expected 0000002A<CR><LF>", q2s()); end
        total++; if (frm_err != 0) begin bad++; $display("FAIL single_frame: got %0d errors expected 0", frm_err); end
    endtask

    task automatic test_coalesce();
        int base = fd_cnt;
        rx_q.delete();
        @(negedge clk);
        data_in = 32'hDEAD_BEEF;
        repeat (50) @(negedge clk);
        data_in = 32'h1;
        repeat (50) @(negedge clk);
        data_in = 32'h2;
        for (int i = 0; i < 4*MSG_CYC && fd_cnt < base + 2; i++) @(negedge clk);
        repeat (100) @(negedge clk);
        total++; if (fd_cnt - base != 2) begin bad++; $display("FAIL coalesce_cnt: got %0d expected 2", fd_cnt - base); end
        total++; if (q2s() != "DEADBEEF<CR><LF>00000002<CR><LF>") begin
            bad++; $display("FAIL coalesce_msg: got %s expected DEADBEEF<CR><LF>00000002<CR><LF>", q2s());
        end
    endtask

    task automatic test_return();
        int base = fd_cnt;
        rx_q.delete();
        @(negedge clk);
        data_in = 32'h5;
        for (int i = 0; i < 2*MSG_CYC && fd_cnt < base + 1; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        data_in = 32'h7;
        repeat (50) @(negedge clk);
        data_in = 32'h6;
        repeat (50) @(negedge clk);
        data_in = 32'h5;
        for (int i = 0; i < 4*MSG_CYC && fd_cnt < base + 3; i++) @(negedge clk);
        repeat (100) @(negedge clk);
        total++; if (fd_cnt - base != 3) begin bad++; $display("FAIL return_cnt: got %0d expected 3", fd_cnt - base); end
        total++; if (q2s() != "00000005<CR><LF>00000007<CR><LF>00000005<CR><LF>") begin
            bad++; $display("FAIL return_msg: got %s expected 00000005<CR><LF>00000007<CR><LF>00000005<CR><LF>", q2s());
        end
        // Value moves away and back to the one being sent: no extra message
        base = fd_cnt;
        rx_q.delete();
        data_in = 32'h9;
        repeat (60) @(negedge clk);
        data_in = 32'h5;
        repeat (60) @(negedge clk);
        data_in = 32'h9;
        for (int i = 0; i < 3*MSG_CYC; i++) @(negedge clk);
        total++; if (fd_cnt - base != 1) begin bad++; $display("FAIL back_cnt: got %0d expected 1", fd_cnt - base); end
        total++; if (q2s() != "00000009<CR><LF>") begin bad++; $display("FAIL back_msg: got %s expected 00000009<CR><LF>", q2s()); end
    endtask

    task automatic test_reset_mid();
        int base;
        rx_q.delete();
        @(negedge clk);
        data_in = 32'h1234_5678;
        repeat (2 + 3*FB*BAUD) @(negedge clk);
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_start: got %b expected 0", tx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b expected 1", busy); end
        total++; if (q2s() != "123") begin bad++; $display("FAIL mid_prefix: got %s expected 123", q2s()); end
        #1 reset = 1'b1;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b expected 1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        rx_q.delete();
        base = fd_cnt;
        data_in = 32'h10;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2*MSG_CYC && fd_cnt < base + 1; i++) @(negedge clk);
        repeat (50) @(negedge clk);
        total++; if (fd_cnt - base != 1) begin bad++; $display("FAIL after_rst_cnt: got %0d expected 1", fd_cnt - base); end
        total++; if (q2s() != "00000010<CR><LF>") begin bad++; $display("FAIL after_rst_msg: got %s expected 00000010<CR><LF>", q2s()); end
        total++; if (frm_err != 0) begin bad++; $display("FAIL frame_errs: got %0d expected 0", frm_err); end
    endtask

`ifdef PORT_UART_HEX_PARITY_EN
    task automatic test_parity();
        int cnt = 0;
        rx_q.delete();
        @(negedge clk);
        data_in = 32'h3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        while (frame_done !== 1'b1 && cnt < 2*MSG_CYC) begin
            @(posedge clk); #1;
            cnt++;
        end
        total++; if (cnt != 440) begin bad++; $display("FAIL parity_len: got %0d expected 440", cnt); end
        @(negedge clk);
        total++; if (q2s() != "00000003<CR><LF>") begin bad++; $display("FAIL parity_msg: got %s expected 00000003<CR><LF>", q2s()); end
        total++; if (frm_err != 0) begin bad++; $display("FAIL parity_bits: got %0d errors expected 0", frm_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_coalesce();
        test_return();
        test_reset_mid();
`ifdef PORT_UART_HEX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/port_out_uart_hex.md
Name: port_out_uart_hex

Overview:
- Downstream consumer of the SimpleCPU output port (port_out_out, 32-bit).
- Watches the port value. On each change it transmits the value over UART as 8 uppercase hex ASCII digits followed by CR LF.
- Gives board-level visibility of the CPU "count" output without a logic analyser.
- Sits between SimpleCPU and the FPGA UART TX pin.

Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200). Minimum 2.
- DATA_WIDTH, 32, port width. Must be a multiple of 4; digit count = DATA_WIDTH/4.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  value from SimpleCPU port_out_out; free-running, no strobe.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a message is being transmitted.
- frame_done  output  1  one-cycle pulse when the final LF stop bit completes.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, frame_done=0.
  - last_sent=0, state=IDLE, all counters 0.
  - Consequence: a port value of 0 after reset is not transmitted.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - Each cycle compare data_in with last_sent.
  - If they differ: snapshot <= data_in, last_sent <= data_in, go to LOAD.
- LOAD (1 cycle):
  - char_idx=0, busy=1.
  - Present character 0 to the byte serializer.
- SEND:
  - Characters in order: hex digit for nibble [DATA_WIDTH-1:DATA_WIDTH-4] first, down to nibble [3:0], then 0x0D, then 0x0A. That is 10 characters at default width.
  - Nibble-to-ASCII: 0-9 maps to 0x30-0x39; A-F maps to 0x41-0x46.
  - Each character frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly BAUD_DIV cycles.
  - Characters are back-to-back: the next start bit begins the cycle after the previous stop bit ends. There is no extra idle time.
- DONE (1 cycle):
  - frame_done=1, busy=0.
  - Return to IDLE.
- Latency: data_in change seen in IDLE at cycle N → tx falls at cycle N+2.
  - Message length = (DATA_WIDTH/4+2) × 10 × BAUD_DIV cycles.
- Coalescing:
  - data_in changes during LOAD/SEND/DONE are ignored.
  - On return to IDLE, data_in is compared with last_sent again. Intermediate values are dropped; the final settled value is always sent.
- data_in that returns to last_sent before IDLE → no new message.
- Reset mid-message: tx goes high immediately and the message is abandoned. After release, nothing is sent until data_in ≠ 0.
- busy is registered and is high from LOAD through the final stop bit.

Optional Feature:
- Macro: PORT_UART_HEX_PARITY_EN.
- Defined: each character frame inserts an even-parity bit (XOR of the 8 data bits) between data bit 7 and the stop bit.
  - Frame = 11 bits; message length = (DATA_WIDTH/4+2) × 11 × BAUD_DIV.
- Undefined: 8N1 frames as above; no parity logic synthesized.

Decomposition:
- Package port_uart_pkg:
  - state enum (IDLE, LOAD, SEND, DONE);
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - function nibble_to_ascii(4-bit) → 8-bit.
- Sub-module uart_tx_byte:
  - Interface: clk, reset, start, byte_in[7:0], tx, ready.
  - Contains the baud counter, bit counter and shift register; honours the parity macro.
  - Top level owns change detection, the snapshot, character sequencing and the FSM.

Test Plan (BAUD_DIV=4, DATA_WIDTH=32; a UART monitor decodes tx):
- Reset then data_in held 0 for 2000 cycles → tx constant 1, busy 0, no frame_done.
- data_in=32'h0000_002A → monitor receives "0000002A\r\n".
  - tx falls 2 cycles after the change.
  - frame_done pulses exactly 400 cycles after the first start bit edge.
- data_in=32'hDEAD_BEEF, then 32'h1 and 32'h2 during transmission → messages received: "DEADBEEF\r\n" then "00000002\r\n" only.
- data_in=5, sent; then 6 and back to 5 during a second message started by 7 → only "00000005", "00000007", "00000005" received.
- Reset asserted mid-message at character 3 → tx=1 within the same cycle, busy=0. After release with data_in=32'h10 → full "00000010\r\n".
- With PORT_UART_HEX_PARITY_EN, data_in=32'h3 → 11-bit frames. Parity bit=0 for '0' (0x30), parity bit=0 for '3' (0x33). Total 440 cycles.
